// File: rtl/async_fifo_if.sv
// Producer/consumer handshake and status bundle for the single-clock FIFO.
interface async_fifo_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, rd_en, wdata,
    input  rdata, full, empty, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, wdata,
    output rdata, full, empty, overflow, underflow
  );
endinterface

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, full/empty status and
// one-cycle overflow/underflow pulses.
module async_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FIFO_SIZE = 16
) (
  input  logic        clk,
  input  logic        res,
  async_fifo_if.slave bus
);
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_SIZE);
  localparam int unsigned CNT_W     = PTR_WIDTH + 1;

  logic [WIDTH-1:0] mem [FIFO_SIZE];
  logic [CNT_W-1:0] wptr;
  logic [CNT_W-1:0] rptr;
  logic [WIDTH-1:0] rdata_q;
  logic             overflow_q;
  logic             underflow_q;

  logic full_c;
  logic empty_c;
  logic wr_acc_c;
  logic rd_acc_c;

  // Extra pointer MSB tells a full ring apart from an empty one.
  assign empty_c  = (wptr == rptr);
  assign full_c   = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                    (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign wr_acc_c = bus.wr_en && !full_c;
  assign rd_acc_c = bus.rd_en && !empty_c;

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wptr[PTR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wptr        <= '0;
      rptr        <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.wr_en && full_c;
      underflow_q <= bus.rd_en && empty_c;
      if (wr_acc_c) begin
        wptr <= wptr + CNT_W'(1);
      end
      if (rd_acc_c) begin
        rdata_q <= mem[rptr[PTR_WIDTH-1:0]];
        rptr    <= rptr + CNT_W'(1);
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_async_fifo.sv
// Randomized bench for async_fifo against a queue-based reference model.
module tb_async_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic res;
  int   errors;
  int   checks;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_rdata;
  logic             exp_ovf;
  logic             exp_udf;
  logic [WIDTH-1:0] written[$];

  async_fifo_if #(.WIDTH(WIDTH)) bus ();

  async_fifo #(.WIDTH(WIDTH), .FIFO_SIZE(DEPTH)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, advance the reference model, sample #1 after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bit full_m;
    bit empty_m;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.wdata = d;
    full_m  = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    exp_ovf = wr && full_m;
    exp_udf = rd && empty_m;
    if (rd && !empty_m) exp_rdata = mq.pop_front();
    if (wr && !full_m) mq.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = '0;
    mq.delete();
    exp_rdata = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b1;
    cyc(1'b0, 1'b0, '0);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.rdata); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err got ovf=%b udf=%b exp 0 0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill_overflow();
    logic [WIDTH-1:0] d;
    written.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      d = WIDTH'($urandom);
      written.push_back(d);
      cyc(1'b1, 1'b0, d);
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, bus.empty); end
      checks++; if (bus.full !== (i == int'(DEPTH) - 1)) begin
        errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, bus.full, (i == int'(DEPTH) - 1));
      end
    end
    cyc(1'b1, 1'b0, 8'hEE);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", bus.overflow); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", bus.full); end
    cyc(1'b0, 1'b0, '0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] prev;
    for (int i = 0; i < int'(DEPTH); i++) begin
      prev = bus.rdata;
      bus.rd_en = 1'b1;
      @(negedge clk);
      checks++; if (bus.rdata !== prev) begin errors++; $display("FAIL drain_early[%0d] got %h exp %h", i, bus.rdata, prev); end
      cyc(1'b0, 1'b1, '0);
      checks++; if (bus.rdata !== written[i]) begin
        errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.rdata, written[i]);
      end
      checks++; if (bus.rdata !== exp_rdata) begin
        errors++; $display("FAIL drain_model[%0d] got %h exp %h", i, bus.rdata, exp_rdata);
      end
      checks++; if (bus.empty !== (i == int'(DEPTH) - 1)) begin
        errors++; $display("FAIL drain_empty[%0d] got %b exp %b", i, bus.empty, (i == int'(DEPTH) - 1));
      end
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b1, '0);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse got %b exp 1", bus.underflow); end
    checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL udf_hold got %h exp %h", bus.rdata, exp_rdata); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL udf_empty got %b exp 1", bus.empty); end
    // Write while empty: the read is still rejected and the new word is not bypassed.
    cyc(1'b1, 1'b1, 8'h3C);
    checks++; if (bus.underflow !== 1'b1 || bus.rdata !== exp_rdata) begin
      errors++; $display("FAIL udf_nobypass got udf=%b rdata=%h exp 1 %h", bus.underflow, bus.rdata, exp_rdata);
    end
    cyc(1'b0, 1'b0, '0);
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got %b exp 0", bus.underflow); end
    cyc(1'b0, 1'b1, '0);
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL udf_late_read got %h exp 3c", bus.rdata); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, WIDTH'($urandom));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, WIDTH'($urandom));
      checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, bus.rdata, exp_rdata); end
      checks++; if (bus.full !== 1'b0 || bus.empty !== 1'b0 || mq.size() != 8) begin
        errors++; $display("FAIL b2b_flags[%0d] got full=%b empty=%b exp 0 0 occ=8", i, bus.full, bus.empty);
      end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
        errors++; $display("FAIL b2b_err[%0d] got ovf=%b udf=%b exp 0 0", i, bus.overflow, bus.underflow);
      end
    end
    while (mq.size() != 0) cyc(1'b0, 1'b1, '0);
  endtask

  task automatic test_random();
    int pw;
    int pr;
    for (int i = 0; i < 300; i++) begin
      pw = (i < 100) ? 80 : (i < 200) ? 20 : 50;
      pr = (i < 100) ? 30 : (i < 200) ? 80 : 50;
      cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, WIDTH'($urandom));
      checks++;
      if (bus.rdata !== exp_rdata || bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0) ||
          bus.overflow !== exp_ovf || bus.underflow !== exp_udf) begin
        errors++;
        $display("FAIL random[%0d] got rd=%h f=%b e=%b o=%b u=%b exp rd=%h f=%b e=%b o=%b u=%b", i,
                 bus.rdata, bus.full, bus.empty, bus.overflow, bus.underflow,
                 exp_rdata, (mq.size() == DEPTH), (mq.size() == 0), exp_ovf, exp_udf);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, WIDTH'($urandom) | 8'h01);
    cyc(1'b0, 1'b1, '0);
    #2;
    res = 1'b0;
    #1;
    mq.delete();
    exp_rdata = '0;
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got empty=%b full=%b exp 1 0", bus.empty, bus.full);
    end
    checks++; if (bus.rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got %h exp 00", bus.rdata); end
    @(posedge clk);
    #1;
    res = 1'b1;
    cyc(1'b1, 1'b0, 8'hA5);
    cyc(1'b0, 1'b1, '0);
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL rstmid_a5 got %h exp a5", bus.rdata); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty_after got %b exp 1", bus.empty); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
